// File: rtl/dds_sample_sequencer_pkg.sv
// rtl/dds_sample_sequencer_pkg.sv - shared state encoding and default widths for the DDS sample sequencer
package dds_sample_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROM_WAIT = 2'd1,
        ST_LOAD     = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 10;
    localparam int DEF_PHASE_W = 16;
    localparam int DEF_CLK_DIV = 5000;
    localparam int DEF_ROM_LAT = 2;
    localparam int FREQ_W      = 10;

endpackage

// File: rtl/dds_sample_sequencer_sample_tick_gen.sv
// rtl/dds_sample_sequencer_sample_tick_gen.sv - sample-rate divider producing a registered one-cycle tick
module dds_sample_sequencer_sample_tick_gen
    import dds_sample_sequencer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sample_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    // Counter parks at zero while disabled so re-enabling gives a full period before the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else if (!enable) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt         <= '0;
            sample_tick <= 1'b1;
        end else begin
            cnt         <= cnt + 1'b1;
            sample_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_sample_sequencer.sv
// rtl/dds_sample_sequencer.sv - tick -> phase accumulate -> ROM wait -> DAC/PWM load sequencer with overrun flag
module dds_sample_sequencer
    import dds_sample_sequencer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = DEF_ROM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [FREQ_W-1:0] freq_step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_load,
    output logic              pwm_load,
    input  logic              dac_busy,
    output logic              sample_tick,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [PHASE_W-1:0]  phase;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_done;
    logic                accept;
    logic                capture;

    dds_sample_sequencer_sample_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sample_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_tick (sample_tick)
    );

    assign wait_done = (wait_cnt == WAIT_W'(ROM_LAT - 1));
    assign rom_addr  = phase[PHASE_W-1 -: ADDR_W];
    assign pwm_load  = dac_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (sample_tick) state_nxt = ST_ROM_WAIT;
            ST_ROM_WAIT: if (wait_done)   state_nxt = ST_LOAD;
            ST_LOAD:     if (!dac_busy)   state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        accept  = (state == ST_IDLE) && sample_tick;
        capture = (state == ST_LOAD) && !dac_busy;
    end

    // A tick outside IDLE is dropped; only the sticky flag records it, and it outranks a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            wait_cnt <= '0;
            dac_data <= '0;
            dac_load <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            dac_load <= capture;
            if (accept) begin
                phase <= phase + PHASE_W'(freq_step);
            end
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == ST_ROM_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                dac_data <= rom_data;
            end
            if (sample_tick && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_sample_sequencer.sv
// tb/tb_dds_sample_sequencer.sv - scoreboard bench for dds_sample_sequencer with transaction-level reference model
module tb_dds_sample_sequencer;

    localparam int CLK_DIV = 8;
    localparam int ROM_LAT = 2;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 10;
    localparam int PHASE_W = 16;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [9:0]        freq_step = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rom_p1;
    logic [DATA_W-1:0] dac_data;
    logic              dac_load;
    logic              pwm_load;
    logic              dac_busy = 1'b0;
    logic              sample_tick;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    exp_t               exp_q[$];
    logic [PHASE_W-1:0] m_phase = '0;
    bit                 m_pending = 1'b0;
    bit                 m_busy_seen = 1'b0;
    bit                 m_ovr = 1'b0;
    bit                 m_addr_chk = 1'b0;
    int                 m_tick_cyc = 0;
    int                 cyc = 0;

    always #5 clk = ~clk;

    dds_sample_sequencer #(
        .CLK_DIV (CLK_DIV),
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .freq_step   (freq_step),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .dac_data    (dac_data),
        .dac_load    (dac_load),
        .pwm_load    (pwm_load),
        .dac_busy    (dac_busy),
        .sample_tick (sample_tick),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    // two-stage ROM: data = addr ^ 0x155, valid ROM_LAT cycles after the address changes
    always @(posedge clk) begin
        rom_p1   <= rom_addr ^ 10'h155;
        rom_data <= rom_p1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor + scoreboard
    always @(negedge clk) begin
        bit set_ovr;
        exp_t e;
        cyc++;
        check("pwm_eq_dac_load", pwm_load, dac_load);
        check("overrun", overrun, m_ovr);
        if (m_addr_chk) begin
            check("rom_addr_after_tick", rom_addr, m_phase[PHASE_W-1 -: ADDR_W]);
            m_addr_chk = 1'b0;
        end
        if (dac_load) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_load: dac_load=1 with no sample outstanding, expected 0 (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("dac_data", dac_data, e.data);
                check("rom_addr_at_load", rom_addr, e.addr);
                if (!m_busy_seen) check("load_latency", cyc - m_tick_cyc, ROM_LAT + 2);
            end
            m_pending = 1'b0;
        end
        if (rst) begin
            exp_q.delete();
            m_phase    = '0;
            m_pending  = 1'b0;
            m_ovr      = 1'b0;
            m_addr_chk = 1'b0;
        end else begin
            if (m_pending && dac_busy) m_busy_seen = 1'b1;
            set_ovr = sample_tick && m_pending;
            if (sample_tick && !m_pending) begin
                m_phase     = m_phase + {6'b0, freq_step};
                e.addr      = m_phase[PHASE_W-1 -: ADDR_W];
                e.data      = e.addr ^ 10'h155;
                exp_q.push_back(e);
                m_pending   = 1'b1;
                m_busy_seen = 1'b0;
                m_tick_cyc  = cyc;
                m_addr_chk  = 1'b1;
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 4 * CLK_DIV);
        n_checks++;
        if (!sample_tick) begin
            n_errors++;
            $display("FAIL tick_timeout: no sample_tick within %0d cycles, expected one", n);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_rom_addr", rom_addr, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_dac_load", dac_load, 0);
        check("rst_pwm_load", pwm_load, 0);
        check("rst_sample_tick", sample_tick, 0);
        check("rst_overrun", overrun, 0);
    endtask

    initial begin
        int loads;
        int ticks;
        int n;
        logic [ADDR_W-1:0] a0;

        repeat (3) step();
        check_reset_outputs();
        rst = 1'b0;
        enable = 1'b1;
        freq_step = 10'd64;

        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            step();
            check("addr_step64", rom_addr, k);
        end

        freq_step = 10'd1023;
        repeat (70) wait_tick();

        for (int i = 0; i < 600; i++) begin
            step();
            if ($urandom_range(7, 0) == 0) freq_step = 10'($urandom);
            dac_busy = ($urandom_range(9, 0) == 0);
            overrun_clr = ($urandom_range(15, 0) == 0);
        end
        dac_busy = 1'b0;
        overrun_clr = 1'b0;
        freq_step = 10'd37;
        repeat (3 * CLK_DIV) step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;

        // backpressure: busy for 20 cycles after a tick
        wait_tick();
        step();
        dac_busy = 1'b1;
        a0 = rom_addr;
        loads = 0;
        repeat (20) begin
            step();
            if (dac_load) loads++;
        end
        check("busy_no_load", loads, 0);
        check("busy_overrun", overrun, 1);
        check("busy_addr_held", rom_addr, a0);
        dac_busy = 1'b0;
        loads = 0;
        repeat (3) begin
            step();
            if (dac_load) loads++;
        end
        check("busy_release_one_load", loads, 1);

        // clear priority: clear alone, then clear coincident with a new overrun
        wait_tick();
        step();
        overrun_clr = 1'b1;
        dac_busy = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("clr_alone_a", overrun, 0);
        repeat (6) step();
        overrun_clr = 1'b1;
        step();
        check("set_beats_clr", overrun, 1);
        step();
        overrun_clr = 1'b0;
        check("clr_alone_b", overrun, 0);
        dac_busy = 1'b0;
        repeat (2 * CLK_DIV) step();

        // enable drop one cycle after a tick
        wait_tick();
        step();
        enable = 1'b0;
        loads = 0;
        ticks = 0;
        repeat (3 * CLK_DIV) begin
            step();
            if (dac_load) loads++;
            if (sample_tick) ticks++;
        end
        check("en_drop_one_load", loads, 1);
        check("en_drop_no_tick", ticks, 0);
        enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sample_tick && n < 4 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("reenable_tick_delay", n, CLK_DIV);

        // reset mid-sample
        wait_tick();
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_outputs();
        repeat (2) step();
        rst = 1'b0;
        loads = 0;
        repeat (CLK_DIV - 1) begin
            step();
            if (dac_load) loads++;
        end
        check("post_rst_no_load", loads, 0);

        freq_step = 10'd0;
        repeat (3) wait_tick();
        repeat (CLK_DIV) step();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dds_sample_sequencer.md
Name: dds_sample_sequencer

Overview:
- Sequences the waveform-generation datapath: sample-rate tick → phase accumulator → ROM address → ROM read → DAC/PWM load.
- Replaces the fixed divider and address-register pair with one controller.
- Adds a frequency-step phase accumulator, a ROM-latency wait, backpressure from the SPI DAC serialiser, and overrun detection.
- Sits between the switch inputs and the ROM / spi2dac / pwm instances in the top level.

Parameters:
- CLK_DIV, 5000: clk cycles per sample tick (≥ ROM_LAT+4)
- PHASE_W, 16: phase accumulator width
- ADDR_W, 10: ROM address width; address = phase[PHASE_W-1 -: ADDR_W]
- DATA_W, 10: sample width
- ROM_LAT, 2: clk cycles from rom_addr change to valid rom_data (≥1)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- enable  in  1  run control; when low, no new ticks
- freq_step  in  10  phase increment per tick, zero-extended to PHASE_W
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM output
- dac_data  out  DATA_W  sample to spi2dac and pwm
- dac_load  out  1  one-cycle load pulse to spi2dac
- pwm_load  out  1  one-cycle load pulse to pwm, coincident with dac_load
- dac_busy  in  1  spi2dac transfer in progress
- sample_tick  out  1  one-cycle pulse per sample period
- overrun  out  1  sticky: a tick arrived before the previous sample was delivered
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (rst=1 at a clk edge):
  - phase=0, tick counter=0, state=IDLE.
  - All outputs 0: rom_addr, dac_data, dac_load, pwm_load, sample_tick, overrun.
- Tick counter:
  - When enable=1, counts 0..CLK_DIV-1, then wraps.
  - sample_tick is a registered output: high for one cycle in the cycle after the counter reaches CLK_DIV-1.
  - When enable=0, the counter is held at 0 and no tick is produced.
- FSM states: IDLE, ROM_WAIT, LOAD.
  - IDLE + tick (cycle T): at the end of T, phase <= phase + freq_step (mod 2^PHASE_W), freq_step sampled here; wait counter <= 0; go to ROM_WAIT.
  - rom_addr is driven directly from the phase register, so it is valid from T+1.
  - ROM_WAIT lasts exactly ROM_LAT cycles (T+1..T+ROM_LAT), then goes to LOAD.
  - LOAD, dac_busy=0: dac_data <= rom_data; dac_load and pwm_load pulse high in the next cycle; return to IDLE.
    - With no stall, dac_load is high in cycle T+ROM_LAT+2, with dac_data valid in the same cycle and held until the next load.
  - LOAD, dac_busy=1: remain in LOAD and keep re-sampling rom_data; there is no timeout.
- Overrun:
  - A tick arriving in any state other than IDLE sets overrun.
  - That tick is dropped: phase does not advance and the in-flight sample is not disturbed.
  - overrun_clr clears overrun. If a set and a clear occur in the same cycle, the set wins.
- Enable deasserted mid-sample: the in-flight sample completes, with exactly one load pulse; the FSM then rests in IDLE.
- Reset mid-operation: abandon immediately; no load pulse is issued.
- freq_step=0: ticks still produce loads at a constant address.
- Arithmetic: unsigned addition with natural wrap; no saturation.

Decomposition:
- Shared package:
  - state encoding (IDLE/ROM_WAIT/LOAD)
  - default widths ADDR_W=10, DATA_W=10, PHASE_W=16
  - default CLK_DIV=5000
- Sub-module sample_tick_gen: parameterised divider with enable and sync reset, producing sample_tick.
- FSM, phase accumulator and overrun logic live in the parent.

Test Plan:
- Reset: assert rst 3 cycles during activity → every output 0 on the next cycle; no dac_load for CLK_DIV-1 cycles after release.
- Tick/load timing (CLK_DIV=8, ROM_LAT=2, ROM model data=addr^0x155, freq_step=64, dac_busy=0):
  - rom_addr = 1, 2, 3… on successive ticks.
  - dac_load and pwm_load high exactly 4 cycles after each sample_tick, with dac_data = addr^0x155.
- Wrap-around: freq_step=1023 for 70 ticks → rom_addr tracks (n·1023 mod 65536)>>6 each tick, including the wrap.
- Backpressure (CLK_DIV=8): hold dac_busy=1 for 20 cycles after a tick.
  - No load while busy; overrun=1 on the next tick; dropped ticks do not advance rom_addr.
  - Exactly one dac_load after busy falls.
- Overrun clear priority: assert overrun_clr in the same cycle as a new overrun event → overrun stays 1; overrun_clr alone on the next cycle → 0.
- Enable drop: deassert enable one cycle after sample_tick → exactly one further dac_load, then no sample_tick for 3·CLK_DIV cycles; re-enable → ticks resume CLK_DIV cycles later.
